// File: rtl/mips_isa_pkg.sv
// MIPS32 encoding constants, instruction classes and field positions shared
// by the fetch/decode pipeline and the ID stage.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    ICLASS_R = 2'd0,
    ICLASS_I = 2'd1,
    ICLASS_J = 2'd2
  } iclass_t;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int REG_W      = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_W     = 26;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_field_decode.sv
// Pure combinational split of a 32-bit MIPS instruction into all of its
// fields; every field is driven regardless of class so consumers never see stale bits.
module mips_field_decode
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] imm_sext,
  output logic [25:0] addr26,
  output logic [1:0]  iclass
);

  iclass_t cls;

  assign opcode   = instr[OPCODE_LSB +: OPCODE_W];
  assign rs       = instr[RS_LSB +: REG_W];
  assign rt       = instr[RT_LSB +: REG_W];
  assign rd       = instr[RD_LSB +: REG_W];
  assign shamt    = instr[SHAMT_LSB +: REG_W];
  assign funct    = instr[FUNCT_LSB +: FUNCT_W];
  assign imm16    = instr[IMM_LSB +: IMM_W];
  assign imm_sext = sext16(instr[IMM_LSB +: IMM_W]);
  assign addr26   = instr[ADDR_LSB +: ADDR_W];

  always_comb begin
    cls = ICLASS_I;
    if (opcode == OP_RTYPE) begin
      cls = ICLASS_R;
    end else if (opcode == OP_J || opcode == OP_JAL) begin
      cls = ICLASS_J;
    end
  end

  assign iclass = cls;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready on both sides, a 2-entry skid
// buffer giving fetch a registered ready, synchronous flush, and field decode.
//
// state | meaning
// EMPTY | no entry held; out_instr = NOP_INSTR, out_pc = 0
// ONE   | main entry valid, skid empty, in_ready = 1
// FULL  | main and skid valid, in_ready = 0, input ignored
module if_id_skid_reg
  import mips_isa_pkg::*;
#(
  parameter int                   PC_W      = 9,
  parameter int                   INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [31:0]        imm_sext,
  output logic [25:0]        addr26,
  output logic [1:0]         iclass
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_t;

  buf_state_t state, state_n;

  logic [INSTR_W-1:0] main_instr, main_instr_n;
  logic [PC_W-1:0]    main_pc, main_pc_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [PC_W-1:0]    skid_pc, skid_pc_n;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);
  assign in_ready   = !skid_valid;
  assign out_valid  = main_valid;
  assign out_instr  = main_instr;
  assign out_pc     = main_pc;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      main_instr <= main_instr_n;
      main_pc    <= main_pc_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    main_instr_n = main_instr;
    main_pc_n    = main_pc;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;

    if (flush) begin
      // same-cycle accept is dropped; a same-cycle pop is simply consumed
      state_n      = ST_EMPTY;
      main_instr_n = NOP_INSTR;
      main_pc_n    = '0;
      skid_instr_n = '0;
      skid_pc_n    = '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_n      = ST_ONE;
            main_instr_n = in_instr;
            main_pc_n    = in_pc;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_instr_n = in_instr;
            main_pc_n    = in_pc;
          end else if (accept) begin
            state_n      = ST_FULL;
            skid_instr_n = in_instr;
            skid_pc_n    = in_pc;
          end else if (pop) begin
            state_n      = ST_EMPTY;
            main_instr_n = NOP_INSTR;
            main_pc_n    = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_n      = ST_ONE;
            main_instr_n = skid_instr;
            main_pc_n    = skid_pc;
            skid_instr_n = '0;
            skid_pc_n    = '0;
          end
        end
        default: begin
          state_n      = ST_EMPTY;
          main_instr_n = NOP_INSTR;
          main_pc_n    = '0;
          skid_instr_n = '0;
          skid_pc_n    = '0;
        end
      endcase
    end
  end

  // Only 32-bit encodings are decoded; INSTR_W exists for interface symmetry.
  mips_field_decode u_decode (
    .instr    (out_instr[31:0]),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16),
    .imm_sext (imm_sext),
    .addr26   (addr26),
    .iclass   (iclass)
  );

  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    skid_valid |-> main_valid);

  a_ready_is_not_skid: assert property (@(posedge clk) disable iff (reset)
    in_ready == !skid_valid);

  a_hold_when_stalled: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=>
      ($stable(out_instr) && $stable(out_pc) && out_valid));

endmodule
